// File: rtl/inst_queue.sv
// ============================================================================
// Module   : inst_queue
// Purpose  : Fetch-to-decode packet FIFO with per-slot valid and prediction
//            fields. Flush empties the queue. Optional empty-queue bypass is
//            enabled with INST_QUEUE_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_queue #(
  parameter int DEPTH    = 8,
  parameter int ID_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [31:0]             enq_pc,
  input  logic [ID_WIDTH*32-1:0]  enq_inst,
  input  logic [ID_WIDTH-1:0]     enq_slot_valid,
  input  logic [ID_WIDTH-1:0]     enq_pred_taken,
  input  logic [ID_WIDTH*32-1:0]  enq_pred_target,
  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [31:0]             deq_pc,
  output logic [ID_WIDTH*32-1:0]  deq_inst,
  output logic [ID_WIDTH-1:0]     deq_slot_valid,
  output logic [ID_WIDTH-1:0]     deq_pred_taken,
  output logic [ID_WIDTH*32-1:0]  deq_pred_target,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]             head_q, head_d;
  logic [AW:0]             tail_q, tail_d;
  logic [31:0]             pc_q     [DEPTH];
  logic [ID_WIDTH*32-1:0]  inst_q   [DEPTH];
  logic [ID_WIDTH-1:0]     sv_q     [DEPTH];
  logic [ID_WIDTH-1:0]     pt_q     [DEPTH];
  logic [ID_WIDTH*32-1:0]  tgt_q    [DEPTH];

  logic          w_empty;
  logic          w_full;
  logic          w_enq_fire;
  logic          w_deq_fire;
  logic [AW-1:0] w_head_idx;
  logic [AW-1:0] w_tail_idx;

  assign w_head_idx = head_q[AW-1:0];
  assign w_tail_idx = tail_q[AW-1:0];
  assign w_empty    = (head_q == tail_q);
  assign w_full     = (head_q[AW] != tail_q[AW]) && (w_head_idx == w_tail_idx);
  assign enq_ready  = !w_full;
  assign count      = tail_q - head_q;
  assign w_deq_fire = !w_empty && deq_ready && !flush;

`ifdef INST_QUEUE_BYPASS_EN
  logic w_bypass;

  // An empty queue forwards the incoming packet; it is only stored if decode stalls.
  assign w_bypass        = w_empty && !flush && enq_valid;
  assign deq_valid       = !w_empty || w_bypass;
  assign deq_pc          = w_bypass ? enq_pc          : pc_q[w_head_idx];
  assign deq_inst        = w_bypass ? enq_inst        : inst_q[w_head_idx];
  assign deq_slot_valid  = w_bypass ? enq_slot_valid  : sv_q[w_head_idx];
  assign deq_pred_taken  = w_bypass ? enq_pred_taken  : pt_q[w_head_idx];
  assign deq_pred_target = w_bypass ? enq_pred_target : tgt_q[w_head_idx];
  assign w_enq_fire      = enq_valid && !w_full && !flush && !(w_bypass && deq_ready);
`else
  assign deq_valid       = !w_empty;
  assign deq_pc          = pc_q[w_head_idx];
  assign deq_inst        = inst_q[w_head_idx];
  assign deq_slot_valid  = sv_q[w_head_idx];
  assign deq_pred_taken  = pt_q[w_head_idx];
  assign deq_pred_target = tgt_q[w_head_idx];
  assign w_enq_fire      = enq_valid && !w_full && !flush;
`endif

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (w_deq_fire) head_d = head_q + 1'b1;
      if (w_enq_fire) tail_d = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      pc_q[w_tail_idx]   <= enq_pc;
      inst_q[w_tail_idx] <= enq_inst;
      sv_q[w_tail_idx]   <= enq_slot_valid;
      pt_q[w_tail_idx]   <= enq_pred_taken;
      tgt_q[w_tail_idx]  <= enq_pred_target;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_inst_queue.sv
// ============================================================================
// Module   : tb_inst_queue
// Purpose  : Self-checking bench for inst_queue against a packet-queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inst_queue;

  localparam int DEPTH    = 8;
  localparam int ID_WIDTH = 2;
`ifdef INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] inst;
    logic [1:0]  sv;
    logic [1:0]  pt;
    logic [63:0] tgt;
  } pkt_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [63:0] enq_inst;
  logic [1:0]  enq_slot_valid;
  logic [1:0]  enq_pred_taken;
  logic [63:0] enq_pred_target;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [63:0] deq_inst;
  logic [1:0]  deq_slot_valid;
  logic [1:0]  deq_pred_taken;
  logic [63:0] deq_pred_target;
  logic [3:0]  count;

  inst_queue #(.DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .enq_valid       (enq_valid),
    .enq_ready       (enq_ready),
    .enq_pc          (enq_pc),
    .enq_inst        (enq_inst),
    .enq_slot_valid  (enq_slot_valid),
    .enq_pred_taken  (enq_pred_taken),
    .enq_pred_target (enq_pred_target),
    .deq_valid       (deq_valid),
    .deq_ready       (deq_ready),
    .deq_pc          (deq_pc),
    .deq_inst        (deq_inst),
    .deq_slot_valid  (deq_slot_valid),
    .deq_pred_taken  (deq_pred_taken),
    .deq_pred_target (deq_pred_target),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  pkt_t mq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t mk_pkt(input logic [31:0] pc);
    pkt_t p;
    p.pc   = pc;
    p.inst = {$urandom, $urandom};
    p.sv   = 2'($urandom);
    p.pt   = 2'($urandom);
    p.tgt  = {$urandom, $urandom};
    return p;
  endfunction

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input bit ev, input bit dr, input bit fl, input pkt_t p, output bit taken);
    int   sz;
    bit   byp;
    pkt_t h;
    enq_valid       = ev;
    deq_ready       = dr;
    flush           = fl;
    enq_pc          = p.pc;
    enq_inst        = p.inst;
    enq_slot_valid  = p.sv;
    enq_pred_taken  = p.pt;
    enq_pred_target = p.tgt;
    #1;
    sz  = mq.size();
    byp = BYP && (sz == 0) && ev && !fl;
    chk("count", 64'(count), 64'(sz));
    chk("enq_ready", 64'(enq_ready), 64'(sz < DEPTH));
    chk("deq_valid", 64'(deq_valid), 64'((sz > 0) || byp));
    if ((sz > 0) || byp) begin
      h = byp ? p : mq[0];
      chk("deq_pc", 64'(deq_pc), 64'(h.pc));
      chk("deq_inst", deq_inst, h.inst);
      chk("deq_slot_valid", 64'(deq_slot_valid), 64'(h.sv));
      chk("deq_pred_taken", 64'(deq_pred_taken), 64'(h.pt));
      chk("deq_pred_target", deq_pred_target, h.tgt);
    end
    @(posedge clk);
    taken = ev && (sz < DEPTH) && !fl;
    if (fl) begin
      mq.delete();
    end else begin
      if (dr && sz > 0) void'(mq.pop_front());
      if (taken && !(byp && dr)) mq.push_back(p);
    end
    #1;
  endtask

  initial begin
    pkt_t p;
    bit   tk;
    int   sent;
    int   cyc;

    rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_pc = '0; enq_inst = '0; enq_slot_valid = '0; enq_pred_taken = '0; enq_pred_target = '0;
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Single packet
    p = '{pc: 32'h1000, inst: {32'h00500093, 32'h00000013}, sv: 2'b11, pt: 2'b00, tgt: 64'h0};
    step(1, 0, 0, p, tk);
    chk("single_count1", 64'(count), 64'd1);
    step(0, 1, 0, p, tk);
    chk("single_count0", 64'(count), 64'd0);

    // Fill to full, reject 9th, dequeue once
    for (int k = 0; k < DEPTH; k++) step(1, 0, 0, mk_pkt(32'h1100 + 8 * k), tk);
    chk("full_count", 64'(count), 64'd8);
    chk("full_enq_ready", 64'(enq_ready), 64'd0);
    step(1, 0, 0, mk_pkt(32'h1F00), tk);
    chk("full_9th_taken", 64'(tk), 64'd0);
    step(0, 1, 0, p, tk);
    chk("after_deq_enq_ready", 64'(enq_ready), 64'd1);
    while (mq.size() > 0) step(0, 1, 0, p, tk);

    // Wrap-around with random back-pressure
    sent = 0;
    cyc  = 0;
    p = mk_pkt(32'h2000);
    while ((sent < 20 || mq.size() > 0) && cyc < 400) begin
      step(sent < 20, 1'($urandom_range(0, 1)), 0, p, tk);
      chk("wrap_count_max", 64'(count <= 4'd8), 64'd1);
      if (tk) begin
        sent++;
        p = mk_pkt(32'h2000 + 8 * sent);
      end
      cyc++;
    end
    chk("wrap_timeout", 64'(cyc < 400), 64'd1);

    // Simultaneous enqueue and dequeue at count=3
    for (int k = 0; k < 3; k++) step(1, 0, 0, mk_pkt(32'h2800 + 8 * k), tk);
    step(1, 1, 0, mk_pkt(32'h2818), tk);
    chk("simul_count", 64'(count), 64'd3);
    chk("simul_head_pc", 64'(deq_pc), 64'h2808);
    while (mq.size() > 0) step(0, 1, 0, p, tk);

    // Flush with concurrent handshakes
    for (int k = 0; k < 5; k++) step(1, 0, 0, mk_pkt(32'h2900 + 8 * k), tk);
    step(1, 1, 1, mk_pkt(32'h29F0), tk);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_deq_valid", 64'(deq_valid), 64'd0);
    step(1, 0, 0, mk_pkt(32'h3000), tk);
    chk("post_flush_pc", 64'(deq_pc), 64'h3000);
    step(0, 1, 0, p, tk);

    // Asynchronous reset between edges
    for (int k = 0; k < 4; k++) step(1, 0, 0, mk_pkt(32'h4000 + 8 * k), tk);
    chk("pre_arst_count", 64'(count), 64'd4);
    enq_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_deq_valid", 64'(deq_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_enq_ready", 64'(enq_ready), 64'd1);
    mq.delete();
    #1;
    rst = 1'b1;
    step(1, 0, 0, mk_pkt(32'h5000), tk);
    step(1, 1, 0, mk_pkt(32'h5008), tk);
    chk("post_arst_pc", 64'(deq_pc), 64'h5008);
    while (mq.size() > 0) step(0, 1, 0, p, tk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
